adc_dac_pattern_gen: RTL

Parametrised ADC/DAC test-pattern engine for the converter board. It sits between the PLL-derived converter clock and the AD/DA pins. It holds the DAC quiet until the PLL has locked and settled, then drives one of four run-time-selectable patterns, including an ADC-to-DAC loopback. An optional peak detector reports windowed min/max of the ADC stream.

---
 rtl/adc_dac_pattern_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/adc_dac_pattern_gen.sv
// ADC/DAC test-pattern engine: lock-gated DAC start-up, four selectable patterns,
// optional windowed ADC min/max detector enabled by the macro ADC_PEAK_DET_EN.
module adc_dac_pattern_gen #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned SQ_HALF    = 16,
    parameter int unsigned WIN_LEN    = 1024
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] ad_data,
    output logic              ready,
    output logic              da_en,
    output logic [DATA_W-1:0] da_data,
    output logic [DATA_W-1:0] pk_max,
    output logic [DATA_W-1:0] pk_min,
    output logic              pk_valid
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned SQ_W  = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
    localparam logic [DATA_W-1:0] TOP = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t            state, state_nx;
    logic              lock_s1, lock_s2;
    logic [CNT_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] ad_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] phase;
    logic [DATA_W-1:0] tri_val;
    logic              tri_dn;
    logic [SQ_W-1:0]   sq_cnt;
    logic              sq_lvl;
    logic [DATA_W-1:0] sample;
    logic              run_entry;
    logic              mode_upd;

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            ad_q    <= '0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
            ad_q    <= ad_data;
        end
    end

    always_ff @(posedge ad_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lock_s2) state_nx = SETTLE;
            SETTLE:  if (!lock_s2) state_nx = IDLE;
                     else if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = RUN;
            RUN:     if (!lock_s2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ad_clk) begin
        if (rst || state != SETTLE || state_nx != SETTLE) settle_cnt <= '0;
        else                                              settle_cnt <= settle_cnt + CNT_W'(1);
    end

    assign ready     = (state == RUN);
    assign run_entry = (state != RUN) && (state_nx == RUN);
    assign mode_upd  = run_entry || (state == RUN && lock_s2 && mode != mode_q);

    always_comb begin
        case (mode_q)
            2'd0:    sample = phase;
            2'd1:    sample = ad_q;
            2'd2:    sample = tri_val;
            default: sample = {DATA_W{sq_lvl}};
        endcase
    end

    // Outputs are taken from the pre-update generator state, so a mode change shows up one edge later.
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            mode_q  <= '0;
            phase   <= '0;
            tri_val <= '0;
            tri_dn  <= 1'b0;
            sq_cnt  <= '0;
            sq_lvl  <= 1'b0;
            da_en   <= 1'b0;
            da_data <= '0;
        end else begin
            if (state == RUN && lock_s2) begin
                da_en   <= 1'b1;
                da_data <= sample;
            end else begin
                da_en   <= 1'b0;
                da_data <= '0;
            end

            if (mode_upd) mode_q <= mode;

            if (!lock_s2 || mode_upd) begin
                phase   <= '0;
                tri_val <= '0;
                tri_dn  <= 1'b0;
                sq_cnt  <= '0;
                sq_lvl  <= 1'b0;
            end else if (state == RUN) begin
                phase <= phase + DATA_W'(1);

                if (!tri_dn) begin
                    if (tri_val == TOP) begin
                        tri_val <= TOP - DATA_W'(1);
                        tri_dn  <= (DATA_W > 1);
                    end else begin
                        tri_val <= tri_val + DATA_W'(1);
                    end
                end else if (tri_val == DATA_W'(1)) begin
                    tri_val <= '0;
                    tri_dn  <= 1'b0;
                end else begin
                    tri_val <= tri_val - DATA_W'(1);
                end

                if (sq_cnt == SQ_W'(SQ_HALF - 1)) begin
                    sq_cnt <= '0;
                    sq_lvl <= ~sq_lvl;
                end else begin
                    sq_cnt <= sq_cnt + SQ_W'(1);
                end
            end
        end
    end

`ifdef ADC_PEAK_DET_EN
    localparam int unsigned WIN_W = $clog2(WIN_LEN);

    logic [WIN_W-1:0]  win_cnt;
    logic [DATA_W-1:0] run_min, run_max;
    logic [DATA_W-1:0] cur_min, cur_max;

    // The first sample of a window seeds the running values instead of being compared.
    always_comb begin
        cur_min = (win_cnt == '0 || ad_q < run_min) ? ad_q : run_min;
        cur_max = (win_cnt == '0 || ad_q > run_max) ? ad_q : run_max;
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            win_cnt  <= '0;
            run_min  <= '0;
            run_max  <= '0;
            pk_min   <= '0;
            pk_max   <= '0;
            pk_valid <= 1'b0;
        end else begin
            pk_valid <= 1'b0;
            if (state == RUN) begin
                run_min <= cur_min;
                run_max <= cur_max;
                if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                    pk_min   <= cur_min;
                    pk_max   <= cur_max;
                    pk_valid <= 1'b1;
                    win_cnt  <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                end
            end else begin
                win_cnt <= '0;
            end
        end
    end
`else
    assign pk_max   = '0;
    assign pk_min   = '0;
    assign pk_valid = 1'b0;
`endif

endmodule
